rom_port_arbiter: RTL and testbench
===================================

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 16, shared ROM/RAM address width.
REQ-002 SHALL have parameter AVG_BASE, 16'h3000, address offset added to vector-generator addresses.
REQ-003 SHALL have ports: clk_25 in 1, sole clock; reset in 1, synchronous active-high reset.
REQ-004 SHALL have ports: dl_active in 1, HPS download in progress; dl_wr in 1, download byte strobe; dl_addr in ADDR_W, download address; dl_data in 8, download byte.
REQ-005 SHALL have ports: cpu_req in 1, CPU read request (level); cpu_addr in ADDR_W; cpu_ack out 1, one-cycle data-valid pulse; cpu_data out 8; cpu_hold out 1, CPU stall during download.
REQ-006 SHALL have ports: avg_req in 1, vector-generator read request (level); avg_addr in ADDR_W-3; avg_ack out 1; avg_data out 8.
REQ-007 SHALL have ports: mem_addr out ADDR_W; mem_we out 1; mem_wdata out 8; mem_rdata in 8, valid one cycle after mem_addr is driven.
REQ-008 SHALL have ports: dl_done out 1, one-cycle pulse at download end; dl_count out ADDR_W+1, bytes written in last download; overrun out 1, sticky dropped-write flag.

Function
REQ-009 SHALL implement states IDLE, WRITE, RD_CPU, RD_AVG.
REQ-010 SHALL capture every dl_wr into a one-entry write holding register (addr, data, valid) in the cycle it is asserted.
REQ-011 SHALL, from IDLE, grant in priority order: pending write > reads; a write occupies one cycle (WRITE) with mem_we=1, mem_addr/mem_wdata from holding register, valid cleared.
REQ-012 SHALL, when both cpu_req and avg_req are pending and no write, grant the requester not granted last (round-robin bit, reset value CPU-favoured).
REQ-013 SHALL drive mem_addr = cpu_addr in grant cycle for CPU, mem_addr = AVG_BASE + zero-extended avg_addr for AVG, modulo 2^ADDR_W.
REQ-014 SHALL, in RD_CPU/RD_AVG (cycle after grant), register mem_rdata to cpu_data/avg_data and pulse the matching ack for exactly one cycle, then return to IDLE; read latency grant-to-ack = 2 cycles.
REQ-015 SHALL NOT grant any read while dl_active=1; cpu_hold = dl_active OR write pending.
REQ-016 SHALL, on dl_wr while holding register valid and not being drained that cycle, keep old entry, drop new byte, set overrun=1 until reset.
REQ-017 SHALL, on dl_wr in the same cycle the holding entry drains, accept the new byte (no overrun).
REQ-018 SHALL increment a byte counter per accepted dl_wr, clear it on rising edge of dl_active, saturate at 2^ADDR_W.
REQ-019 SHALL, on falling edge of dl_active, load dl_count from the counter and pulse dl_done one cycle after the last pending write completes.
REQ-020 SHALL keep mem_we=0 in every state except WRITE; mem_addr holds last value when idle.
REQ-021 SHALL treat a requester dropping req before ack as abandoned: ack still pulses, data discarded by requester; no stall.

Reset
REQ-022 SHALL on reset: state IDLE, holding valid=0, cpu_ack=avg_ack=0, cpu_data=avg_data=0, mem_addr=0, mem_we=0, mem_wdata=0, dl_done=0, dl_count=0, overrun=0, counter=0, round-robin bit=0.
REQ-023 SHALL abort any in-flight read/write on reset mid-operation without issuing ack or mem_we in the following cycle.

Structure
REQ-024 SHALL place state enum and ADDR_W/AVG_BASE defaults in shared package rom_arb_pkg.
REQ-025 SHALL implement the round-robin read grant as sub-module rr_arb2 (two requesters, one pointer bit); all else flat.

Verification
REQ-026 Download: dl_active=1, 4 bytes 0x11..0x14 to 0x0000..0x0003 every 2 cycles -> four mem_we pulses, correct addr/data, dl_active=0 -> dl_done pulse, dl_count=4, overrun=0.
REQ-027 Back-to-back dl_wr every cycle while a write is held -> overrun=1, dropped byte never written, counter excludes it.
REQ-028 CPU read cpu_addr=0x1234, mem returns 0xA5 -> cpu_ack 2 cycles after grant, cpu_data=0xA5.
REQ-029 cpu_req and avg_req held continuously, avg_addr=0x010 -> grants alternate CPU, AVG, CPU...; AVG mem_addr=0x3010.
REQ-030 cpu_req during dl_active=1 -> cpu_hold=1, no grant until dl_active=0 and holding empty, then ack within 3 cycles.
REQ-031 reset asserted the cycle after a CPU grant -> no cpu_ack, all outputs at reset values next cycle.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared defaults and state/requester encodings for the ROM/RAM port arbiter.
package rom_arb_pkg;

    localparam int          ROM_ADDR_W   = 16;
    localparam logic [31:0] ROM_AVG_BASE = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_RD_CPU = 2'd2,
        ST_RD_AVG = 2'd3
    } arb_state_e;

    // Which reader wins the next tie between CPU and vector generator.
    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_AVG = 1'b1
    } requester_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin read grant: a tie goes to the reader not granted last.
module rr_arb2
    import rom_arb_pkg::*;
(
    input  logic clk_25,
    input  logic reset,
    input  logic enable,
    input  logic req_cpu,
    input  logic req_avg,
    output logic gnt_cpu,
    output logic gnt_avg
);

    requester_e favour_q;
    requester_e favour_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_cpu  = 1'b0;
        gnt_avg  = 1'b0;
        favour_d = favour_q;

        if (enable) begin
            if (req_cpu && (!req_avg || favour_q == REQ_CPU)) begin
                gnt_cpu = 1'b1;
            end else if (req_avg) begin
                gnt_avg = 1'b1;
            end
        end

        if (gnt_cpu) begin
            favour_d = REQ_AVG;
        end else if (gnt_avg) begin
            favour_d = REQ_CPU;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_25) begin
        if (reset) begin
            favour_q <= REQ_CPU;
        end else begin
            favour_q <= favour_d;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one single-port ROM/RAM between HPS download writes, CPU reads and
// vector-generator reads; writes go through a one-entry holding register.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int                ADDR_W   = ROM_ADDR_W,
    parameter logic [ADDR_W-1:0] AVG_BASE = ADDR_W'(ROM_AVG_BASE)
) (
    input  logic              clk_25,
    input  logic              reset,

    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,

    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [7:0]        cpu_data,
    output logic              cpu_hold,

    input  logic              avg_req,
    input  logic [ADDR_W-4:0] avg_addr,
    output logic              avg_ack,
    output logic [7:0]        avg_data,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,

    output logic              dl_done,
    output logic [ADDR_W:0]   dl_count,
    output logic              overrun
);

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    arb_state_e        state_q,      state_d;
    logic              hold_valid_q, hold_valid_d;
    logic [ADDR_W-1:0] hold_addr_q,  hold_addr_d;
    logic [7:0]        hold_data_q,  hold_data_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic              mem_we_q,     mem_we_d;
    logic [7:0]        mem_wdata_q,  mem_wdata_d;
    logic              cpu_ack_q,    cpu_ack_d;
    logic [7:0]        cpu_data_q,   cpu_data_d;
    logic              avg_ack_q,    avg_ack_d;
    logic [7:0]        avg_data_q,   avg_data_d;
    logic              dl_active_q,  dl_active_d;
    logic [ADDR_W:0]   cnt_q,        cnt_d;
    logic [ADDR_W:0]   dl_count_q,   dl_count_d;
    logic              dl_done_q,    dl_done_d;
    logic              done_pend_q,  done_pend_d;
    logic              overrun_q,    overrun_d;

    logic              drain;
    logic              wr_accept;
    logic              done_fire;
    logic              done_want;
    logic [ADDR_W:0]   cnt_base;
    logic              dl_rise;
    logic              dl_fall;
    logic              rd_enable;
    logic              gnt_cpu;
    logic              gnt_avg;
    logic [ADDR_W-1:0] avg_mem_addr;

    assign dl_rise      = dl_active && !dl_active_q;
    assign dl_fall      = !dl_active && dl_active_q;
    assign avg_mem_addr = AVG_BASE + ADDR_W'(avg_addr);

    // Reads wait for the download to finish and for any held byte to land.
    assign rd_enable = (state_q == ST_IDLE) && !hold_valid_q && !dl_active;

    rr_arb2 u_rr_arb2 (
        .clk_25  (clk_25),
        .reset   (reset),
        .enable  (rd_enable),
        .req_cpu (cpu_req),
        .req_avg (avg_req),
        .gnt_cpu (gnt_cpu),
        .gnt_avg (gnt_avg)
    );

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        cpu_ack_d    = 1'b0;
        cpu_data_d   = cpu_data_q;
        avg_ack_d    = 1'b0;
        avg_data_d   = avg_data_q;
        dl_active_d  = dl_active;
        dl_count_d   = dl_count_q;
        overrun_d    = overrun_q;
        drain        = 1'b0;
        wr_accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hold_valid_q) begin
                    drain       = 1'b1;
                    state_d     = ST_WRITE;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = hold_addr_q;
                    mem_wdata_d = hold_data_q;
                end else if (gnt_cpu) begin
                    state_d    = ST_RD_CPU;
                    mem_addr_d = cpu_addr;
                end else if (gnt_avg) begin
                    state_d    = ST_RD_AVG;
                    mem_addr_d = avg_mem_addr;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_RD_CPU: begin
                cpu_ack_d  = 1'b1;
                cpu_data_d = mem_rdata;
                state_d    = ST_IDLE;
            end
            ST_RD_AVG: begin
                avg_ack_d  = 1'b1;
                avg_data_d = mem_rdata;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A byte arriving while the entry drains this cycle takes its place.
        if (drain) begin
            hold_valid_d = 1'b0;
        end
        if (dl_wr) begin
            if (!hold_valid_q || drain) begin
                wr_accept    = 1'b1;
                hold_valid_d = 1'b1;
                hold_addr_d  = dl_addr;
                hold_data_d  = dl_data;
            end else begin
                overrun_d = 1'b1;
            end
        end

        cnt_base = dl_rise ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (wr_accept && !cnt_base[ADDR_W]) begin
            cnt_d = cnt_base + CNT_ONE;
        end

        if (dl_fall) begin
            dl_count_d = cnt_d;
        end

        // Completion waits until the holding register has emptied.
        done_want   = (done_pend_q || dl_fall) && !dl_active;
        done_fire   = done_want && !hold_valid_q && !wr_accept;
        dl_done_d   = done_fire;
        done_pend_d = done_want && !done_fire;
    end

    always_ff @(posedge clk_25) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_data_q   <= '0;
            avg_ack_q    <= 1'b0;
            avg_data_q   <= '0;
            dl_active_q  <= 1'b0;
            cnt_q        <= '0;
            dl_count_q   <= '0;
            dl_done_q    <= 1'b0;
            done_pend_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_data_q   <= cpu_data_d;
            avg_ack_q    <= avg_ack_d;
            avg_data_q   <= avg_data_d;
            dl_active_q  <= dl_active_d;
            cnt_q        <= cnt_d;
            dl_count_q   <= dl_count_d;
            dl_done_q    <= dl_done_d;
            done_pend_q  <= done_pend_d;
            overrun_q    <= overrun_d;
        end
    end

    assign cpu_hold  = dl_active || hold_valid_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_data  = cpu_data_q;
    assign avg_ack   = avg_ack_q;
    assign avg_data  = avg_data_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign dl_done   = dl_done_q;
    assign dl_count  = dl_count_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: downloads, overrun, CPU/AVG reads, hold, reset abort.
module tb_rom_port_arbiter;

    logic        clk_25 = 1'b0;
    logic        reset;
    logic        dl_active;
    logic        dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_ack;
    logic [7:0]  cpu_data;
    logic        cpu_hold;
    logic        avg_req;
    logic [12:0] avg_addr;
    logic        avg_ack;
    logic [7:0]  avg_data;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        dl_done;
    logic [16:0] dl_count;
    logic        overrun;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] log_addr[$];
    logic [7:0]  log_data[$];

    rom_port_arbiter #(
        .ADDR_W   (16),
        .AVG_BASE (16'h3000)
    ) dut (
        .clk_25    (clk_25),
        .reset     (reset),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_ack   (cpu_ack),
        .cpu_data  (cpu_data),
        .cpu_hold  (cpu_hold),
        .avg_req   (avg_req),
        .avg_addr  (avg_addr),
        .avg_ack   (avg_ack),
        .avg_data  (avg_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dl_done   (dl_done),
        .dl_count  (dl_count),
        .overrun   (overrun)
    );

    always #20 clk_25 = ~clk_25;

    // ROM contents: 0x1234 holds 0xA5, every other byte is low address byte ^ 0x5A.
    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        if (a == 16'h1234) return 8'hA5;
        return a[7:0] ^ 8'h5A;
    endfunction

    assign mem_rdata = rom_byte(mem_addr);

    always @(negedge clk_25) begin
        if (mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk_25);
    endtask

    task automatic send_byte(input logic [15:0] a, input logic [7:0] d);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        tick();
        dl_wr   = 1'b0;
    endtask

    task automatic wait_dl_done(input string tag, input int exp_writes);
        bit seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            tick();
            seen = dl_done;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_writes_at_done"}, 32'(log_addr.size()), 32'(exp_writes));
        tick();
        check({tag, "_done_one_cycle"}, 32'(dl_done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acks;
        bit seen;

        reset     = 1'b1;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        avg_req   = 1'b0;
        avg_addr  = '0;
        tick();
        tick();

        check("rst_cpu_ack",  32'(cpu_ack),  32'd0);
        check("rst_mem_we",   32'(mem_we),   32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_dl_count", 32'(dl_count), 32'd0);
        check("rst_overrun",  32'(overrun),  32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        reset = 1'b0;
        tick();

        // Four bytes 0x11..0x14 to 0x0000..0x0003, one every two cycles.
        log_addr.delete();
        log_data.delete();
        dl_active = 1'b1;
        tick();
        check("dl4_cpu_hold", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send_byte(16'(i), 8'h11 + 8'(i));
            tick();
        end
        dl_active = 1'b0;
        wait_dl_done("dl4", 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dl4_addr%0d", i), 32'(log_addr[i]), 32'(i));
            check($sformatf("dl4_data%0d", i), 32'(log_data[i]), 32'h11 + 32'(i));
        end
        check("dl4_count",   32'(dl_count), 32'd4);
        check("dl4_overrun", 32'(overrun),  32'd0);

        // Back-to-back bytes: second lands on a drain cycle, third hits a full register.
        log_addr.delete();
        log_data.delete();
        dl_active = 1'b1;
        tick();
        send_byte(16'h0100, 8'h21);
        send_byte(16'h0101, 8'h22);
        send_byte(16'h0102, 8'h23);
        dl_active = 1'b0;
        wait_dl_done("ovr", 2);
        check("ovr_addr0",   32'(log_addr[0]), 32'h0100);
        check("ovr_data0",   32'(log_data[0]), 32'h21);
        check("ovr_addr1",   32'(log_addr[1]), 32'h0101);
        check("ovr_data1",   32'(log_data[1]), 32'h22);
        check("ovr_flag",    32'(overrun),     32'd1);
        check("ovr_count",   32'(dl_count),    32'd2);

        // CPU read of 0x1234: address out one cycle after grant, ack one cycle later.
        cpu_addr = 16'h1234;
        cpu_req  = 1'b1;
        tick();
        check("cpu_rd_addr",     32'(mem_addr), 32'h1234);
        check("cpu_rd_ack_early", 32'(cpu_ack), 32'd0);
        tick();
        check("cpu_rd_ack",  32'(cpu_ack),  32'd1);
        check("cpu_rd_data", 32'(cpu_data), 32'hA5);
        cpu_req = 1'b0;
        tick();
        check("cpu_rd_ack_pulse", 32'(cpu_ack),  32'd0);
        check("cpu_rd_addr_hold", 32'(mem_addr), 32'h1234);
        check("cpu_rd_no_we",     32'(mem_we),   32'd0);

        // Lone AVG read, then both held: grants alternate CPU, AVG, CPU, AVG.
        avg_addr = 13'h010;
        avg_req  = 1'b1;
        tick();
        check("avg_rd_addr", 32'(mem_addr), 32'h3010);
        tick();
        check("avg_rd_ack",  32'(avg_ack),  32'd1);
        check("avg_rd_data", 32'(avg_data), 32'h4A);
        cpu_addr = 16'h0042;
        cpu_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr_addr%0d", k), 32'(mem_addr), (k % 2 == 0) ? 32'h0042 : 32'h3010);
            tick();
            check($sformatf("rr_cpu_ack%0d", k), 32'(cpu_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr_avg_ack%0d", k), 32'(avg_ack), (k % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("rr_data%0d", k),
                  (k % 2 == 0) ? 32'(cpu_data) : 32'(avg_data),
                  (k % 2 == 0) ? 32'h18 : 32'h4A);
        end
        cpu_req = 1'b0;
        avg_req = 1'b0;
        tick();
        tick();

        // CPU read requested during a download waits, then completes quickly.
        dl_active = 1'b1;
        cpu_addr  = 16'h1234;
        cpu_req   = 1'b1;
        send_byte(16'h0200, 8'h33);
        check("hold_cpu_hold", 32'(cpu_hold), 32'd1);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpu_ack) acks++;
        end
        check("hold_no_ack", 32'(acks), 32'd0);
        dl_active = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3 && !seen; i++) begin
            tick();
            seen = cpu_ack;
        end
        check("hold_ack_in_3", 32'(seen), 32'd1);
        check("hold_ack_data", 32'(cpu_data), 32'hA5);
        cpu_req = 1'b0;
        tick();
        tick();

        // Reset the cycle after a CPU grant: no ack, everything back to reset values.
        cpu_addr = 16'h0777;
        cpu_req  = 1'b1;
        tick();
        check("abort_granted", 32'(mem_addr), 32'h0777);
        reset = 1'b1;
        tick();
        check("abort_cpu_ack",   32'(cpu_ack),   32'd0);
        check("abort_mem_we",    32'(mem_we),    32'd0);
        check("abort_mem_addr",  32'(mem_addr),  32'd0);
        check("abort_mem_wdata", 32'(mem_wdata), 32'd0);
        check("abort_cpu_data",  32'(cpu_data),  32'd0);
        check("abort_avg_data",  32'(avg_data),  32'd0);
        check("abort_overrun",   32'(overrun),   32'd0);
        check("abort_dl_count",  32'(dl_count),  32'd0);
        check("abort_dl_done",   32'(dl_done),   32'd0);
        reset   = 1'b0;
        cpu_req = 1'b0;
        tick();
        check("abort_no_late_ack", 32'(cpu_ack), 32'd0);

        // After reset a tie goes to the CPU.
        cpu_req = 1'b1;
        avg_req = 1'b1;
        tick();
        check("rst_rr_cpu_first", 32'(mem_addr), 32'h0777);
        cpu_req = 1'b0;
        avg_req = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
